// File: rtl/tone_scheduler.sv
// tone_scheduler: fixed-priority arbiter plus millisecond sequencer sharing one tone generator.
// Optional feature macro TONE_PREEMPT_EN: a higher-priority request aborts the running tone or gap.
module tone_scheduler #(
   parameter int FCLK   = 50_000_000,
   parameter int N_REQ  = 4,
   parameter int GAP_MS = 10
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [32*N_REQ-1:0]      req_freq,
   input  logic [16*N_REQ-1:0]      req_dur_ms,
   output logic [N_REQ-1:0]         ack,
   output logic [N_REQ-1:0]         done,
   output logic [N_REQ-1:0]         abort,
   output logic [31:0]              freq,
   output logic                     tone_en,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] gnt_id
);
   localparam int DIV = FCLK / 1000;
   localparam int PW  = $clog2(DIV);
   localparam int IW  = $clog2(N_REQ);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
   localparam logic [15:0]   GAP_LAST = (GAP_MS > 0) ? 16'(GAP_MS - 1) : 16'd0;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [15:0]     dur_cnt_q, dur_cnt_d;
   logic [15:0]     gap_cnt_q, gap_cnt_d;
   logic [15:0]     dur_q, dur_d;
   logic [N_REQ-1:0] ack_q, ack_d, done_q, done_d, abort_q, abort_d;
   logic [31:0]     freq_q, freq_d;
   logic            tone_en_q, tone_en_d;
   logic            busy_q, busy_d;
   logic [IW-1:0]   gnt_q, gnt_d;

   logic [31:0]     freq_arr [N_REQ];
   logic [15:0]     dur_arr  [N_REQ];
   logic            win_found;
   logic [IW-1:0]   win_id;
   logic [31:0]     sel_freq;
   logic [15:0]     sel_dur;
   logic            tick;
   logic            preempt;
   logic            grant;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign freq_arr[gi] = req_freq[32*gi +: 32];
         assign dur_arr[gi]  = req_dur_ms[16*gi +: 16];
      end
   endgenerate

   // Lowest set index wins: scan from the top so the last hit is the winner.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_found = 1'b1;
            win_id    = IW'(i);
         end
      end
   end

   assign sel_freq = freq_arr[win_id];
   assign sel_dur  = dur_arr[win_id];
   assign tick     = (pre_q == PRE_LAST);

`ifdef TONE_PREEMPT_EN
   assign preempt = win_found && (win_id < gnt_q);
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      pre_d     = pre_q;
      dur_cnt_d = dur_cnt_q;
      gap_cnt_d = gap_cnt_q;
      dur_d     = dur_q;
      ack_d     = '0;
      done_d    = '0;
      abort_d   = '0;
      freq_d    = freq_q;
      tone_en_d = tone_en_q;
      gnt_d     = gnt_q;
      grant     = 1'b0;

      if (state_q != S_IDLE) begin
         pre_d = tick ? '0 : pre_q + PW'(1);
      end

      case (state_q)
         S_IDLE: begin
            grant = win_found;
         end
         S_PLAY: begin
            if (preempt) begin
               done_d[gnt_q]  = 1'b1;
               abort_d[gnt_q] = 1'b1;
               grant          = 1'b1;
            end else if (dur_q == 16'd0) begin
               done_d[gnt_q] = 1'b1;
               state_d       = S_IDLE;
            end else if (tick) begin
               // Compare before increment so the 16-bit counter never wraps.
               if (dur_cnt_q == dur_q - 16'd1) begin
                  done_d[gnt_q] = 1'b1;
                  tone_en_d     = 1'b0;
                  freq_d        = '0;
                  if (GAP_MS > 0) begin
                     state_d   = S_GAP;
                     gap_cnt_d = '0;
                     pre_d     = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  dur_cnt_d = dur_cnt_q + 16'd1;
               end
            end
         end
         S_GAP: begin
            if (preempt) begin
               grant = 1'b1;
            end else if (tick) begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_d = S_IDLE;
                  grant   = win_found;
               end else begin
                  gap_cnt_d = gap_cnt_q + 16'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A zero-length request still passes through PLAY for one cycle to emit its done.
      if (grant) begin
         ack_d[win_id] = 1'b1;
         gnt_d         = win_id;
         dur_d         = sel_dur;
         dur_cnt_d     = '0;
         pre_d         = '0;
         state_d       = S_PLAY;
         freq_d        = (sel_dur == 16'd0) ? 32'd0 : sel_freq;
         tone_en_d     = (sel_dur != 16'd0) && (sel_freq != 32'd0);
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         pre_q     <= '0;
         dur_cnt_q <= '0;
         gap_cnt_q <= '0;
         dur_q     <= '0;
         ack_q     <= '0;
         done_q    <= '0;
         abort_q   <= '0;
         freq_q    <= '0;
         tone_en_q <= 1'b0;
         busy_q    <= 1'b0;
         gnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         dur_cnt_q <= dur_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         dur_q     <= dur_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
         freq_q    <= freq_d;
         tone_en_q <= tone_en_d;
         busy_q    <= busy_d;
         gnt_q     <= gnt_d;
      end
   end

   assign ack     = ack_q;
   assign done    = done_q;
   assign abort   = abort_q;
   assign freq    = freq_q;
   assign tone_en = tone_en_q;
   assign busy    = busy_q;
   assign gnt_id  = gnt_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed scoreboard bench for tone_scheduler (10 cycles/ms, 4 requesters, 2 ms gap).
// Expectations follow TONE_PREEMPT_EN when the macro is defined for the build.
module tb_tone_scheduler;
   localparam int N = 4;
   localparam int K_ACK = 0, K_DONE = 1, K_ABT = 2;

   typedef struct packed {
      int         cyc;
      logic [1:0] kind;
      logic [1:0] id;
   } ev_t;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req;
   logic [32*N-1:0] req_freq;
   logic [16*N-1:0] req_dur_ms;
   logic [N-1:0]    ack, done, abort;
   logic [31:0]     freq;
   logic            tone_en, busy;
   logic [1:0]      gnt_id;

   int  cyc = 0;
   int  ton_cnt = 0, busy_cnt = 0;
   int  ton0, busy0;
   int  checks = 0, errors = 0;
   ev_t obs_q[$];
   ev_t exp_q[$];

   tone_scheduler #(.FCLK(10_000), .N_REQ(N), .GAP_MS(2)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_freq(req_freq),
      .req_dur_ms(req_dur_ms), .ack(ack), .done(done), .abort(abort),
      .freq(freq), .tone_en(tone_en), .busy(busy), .gnt_id(gnt_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every ack/done/abort pulse, ordered by cycle, kind, id.
   always @(negedge clk) begin
      ev_t  e;
      logic bit_v;
      if (tone_en === 1'b1) ton_cnt++;
      if (busy === 1'b1) busy_cnt++;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < N; i++) begin
            bit_v = (k == K_ACK) ? ack[i] : (k == K_DONE) ? done[i] : abort[i];
            if (bit_v === 1'b1) begin
               e.cyc  = cyc;
               e.kind = k[1:0];
               e.id   = i[1:0];
               obs_q.push_back(e);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run_until(input int target);
      while (cyc < target) step();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_ev(input int c, input int k, input int i);
      ev_t e;
      e.cyc  = c;
      e.kind = k[1:0];
      e.id   = i[1:0];
      exp_q.push_back(e);
   endtask

   task automatic compare_events(input string tag);
      ev_t e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front();
         else begin
            o.cyc = -1; o.kind = 2'b11; o.id = 2'b11;
         end
         checks++;
         assert (o === e) else begin
            errors++;
            $error("FAIL %s_event observed cyc=%0d kind=%0d id=%0d expected cyc=%0d kind=%0d id=%0d",
                   tag, o.cyc, o.kind, o.id, e.cyc, e.kind, e.id);
         end
      end
      chk({tag, "_extra_events"}, obs_q.size(), 0);
      obs_q.delete();
   endtask

   task automatic snap();
      ton0  = ton_cnt;
      busy0 = busy_cnt;
   endtask

   task automatic set_req(input int idx, input int f, input int d);
      req[idx] = 1'b1;
      req_freq[32*idx +: 32] = f;
      req_dur_ms[16*idx +: 16] = d[15:0];
   endtask

   task automatic clr_req(input int idx);
      req[idx] = 1'b0;
   endtask

   task automatic wait_ack(input int idx, input int limit);
      int n = 0;
      while (ack[idx] !== 1'b1 && n < limit) begin
         step();
         n++;
      end
      chk($sformatf("ack%0d_seen", idx), ack[idx], 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_abort"}, abort, 0);
      chk({tag, "_freq"}, freq, 0);
      chk({tag, "_tone_en"}, tone_en, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_gnt_id"}, gnt_id, 0);
   endtask

   initial begin
      int g, pa, tend, ton_exp, busy_exp;
      reset_n = 1'b0; req = '0; req_freq = '0; req_dur_ms = '0;
      repeat (3) step();
      chk_all_zero("reset");
      reset_n = 1'b1;
      repeat (2) step();

      // Single tone on requester 2
      snap();
      set_req(2, 440, 3);
      g = cyc + 1;
      expect_ev(g, K_ACK, 2);
      expect_ev(g + 30, K_DONE, 2);
      step();
      chk("single_ack", ack, 4'b0100);
      chk("single_freq", freq, 440);
      chk("single_tone_en", tone_en, 1);
      chk("single_busy", busy, 1);
      chk("single_gnt", gnt_id, 2);
      clr_req(2);
      run_until(g + 35);
      chk("single_gap_tone_en", tone_en, 0);
      chk("single_gap_freq", freq, 0);
      chk("single_gap_busy", busy, 1);
      run_until(g + 55);
      chk("single_idle_busy", busy, 0);
      chk("single_tone_cycles", ton_cnt - ton0, 30);
      chk("single_busy_cycles", busy_cnt - busy0, 50);
      compare_events("single");

      // Simultaneous requests 1 and 3
      snap();
      set_req(1, 1000, 2);
      set_req(3, 2000, 1);
      g = cyc + 1;
      expect_ev(g, K_ACK, 1);
      expect_ev(g + 20, K_DONE, 1);
      expect_ev(g + 40, K_ACK, 3);
      expect_ev(g + 50, K_DONE, 3);
      step();
      chk("prio_ack", ack, 4'b0010);
      chk("prio_gnt", gnt_id, 1);
      clr_req(1);
      wait_ack(3, 100);
      chk("prio_ack3_cyc", cyc, g + 40);
      chk("prio_freq3", freq, 2000);
      clr_req(3);
      run_until(g + 75);
      chk("prio_idle_busy", busy, 0);
      chk("prio_tone_cycles", ton_cnt - ton0, 30);
      chk("prio_busy_cycles", busy_cnt - busy0, 70);
      compare_events("prio");

      // Rest tone: freq 0, 2 ms
      snap();
      set_req(0, 0, 2);
      g = cyc + 1;
      expect_ev(g, K_ACK, 0);
      expect_ev(g + 20, K_DONE, 0);
      step();
      chk("rest_tone_en", tone_en, 0);
      chk("rest_busy", busy, 1);
      clr_req(0);
      run_until(g + 45);
      chk("rest_tone_cycles", ton_cnt - ton0, 0);
      chk("rest_busy_cycles", busy_cnt - busy0, 40);
      compare_events("rest");

      // Zero duration
      snap();
      set_req(1, 500, 0);
      g = cyc + 1;
      expect_ev(g, K_ACK, 1);
      expect_ev(g + 1, K_DONE, 1);
      step();
      chk("zero_busy", busy, 1);
      clr_req(1);
      step();
      chk("zero_done", done, 4'b0010);
      chk("zero_busy_after", busy, 0);
      run_until(g + 5);
      chk("zero_tone_cycles", ton_cnt - ton0, 0);
      chk("zero_busy_cycles", busy_cnt - busy0, 1);
      compare_events("zero");

      // Higher-priority request arriving 15 cycles into a 5 ms tone
      snap();
      set_req(3, 3000, 5);
      g = cyc + 1;
      expect_ev(g, K_ACK, 3);
      step();
      clr_req(3);
      run_until(g + 14);
      set_req(0, 4000, 1);
`ifdef TONE_PREEMPT_EN
      expect_ev(g + 15, K_ACK, 0);
      expect_ev(g + 15, K_DONE, 3);
      expect_ev(g + 15, K_ABT, 3);
      expect_ev(g + 25, K_DONE, 0);
      pa = g + 15; tend = g + 45; ton_exp = 25; busy_exp = 45;
`else
      expect_ev(g + 50, K_DONE, 3);
      expect_ev(g + 70, K_ACK, 0);
      expect_ev(g + 80, K_DONE, 0);
      pa = g + 70; tend = g + 100; ton_exp = 60; busy_exp = 100;
`endif
      wait_ack(0, 150);
      chk("pre_ack0_cyc", cyc, pa);
      chk("pre_freq0", freq, 4000);
      chk("pre_tone_en0", tone_en, 1);
      chk("pre_gnt0", gnt_id, 0);
      clr_req(0);
      run_until(tend + 5);
      chk("pre_idle_busy", busy, 0);
      chk("pre_tone_cycles", ton_cnt - ton0, ton_exp);
      chk("pre_busy_cycles", busy_cnt - busy0, busy_exp);
      compare_events("preempt");

      // Reset pulse in the middle of a tone
      snap();
      set_req(2, 440, 3);
      g = cyc + 1;
      expect_ev(g, K_ACK, 2);
      step();
      clr_req(2);
      run_until(g + 11);
      chk("midrst_tone_before", tone_en, 1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk_all_zero("midrst");
      run_until(g + 60);
      chk("midrst_tone_cycles", ton_cnt - ton0, 12);
      chk("midrst_busy_end", busy, 0);
      compare_events("midrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
